onehot_encoder_pipe: RTL
========================

Name: onehot_encoder_pipe

Overview:
- Parametrised successor to the fixed 8-to-3 one-hot encoder: N-input request vector to $clog2(N)-bit index.
- Priority resolution for multi-hot inputs, explicit zero/multi-hot flags instead of X, registered output with valid/ready handshake, saturating error counter.
- Sits between request sources (interrupt lines, functional-unit ready bits) and downstream consumers that need a binary index.

Parameters:
- N, 8, number of request inputs; legal range 2..64.
- W, $clog2(N), index width; derived, must not be overridden.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- resetn  input  1  synchronous reset, active-low.
- in_valid  input  1  in_req is valid this cycle.
- in_ready  output  1  block can accept in_req this cycle.
- in_req  input  N  request vector; bit i maps to index i.
- out_valid  output  1  out_idx/flags hold a result.
- out_ready  input  1  consumer accepts result this cycle.
- out_idx  output  W  encoded index of the selected request.
- out_zero  output  1  captured vector was all-zero.
- out_multi  output  1  captured vector had more than one bit set.
- err_cnt  output  ERR_W  saturating count of accepted zero or multi-hot vectors.

Behaviour:
- Reset (resetn=0 at a clk edge): out_valid=0, out_idx=0, out_zero=0, out_multi=0, err_cnt=0, round-robin pointer=0. Reset overrides any handshake in the same cycle; a pending result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input is accepted when in_valid && in_ready.
  - Output transfer completes when out_valid && out_ready.
- Latency: accepted input appears on outputs the next cycle, so out_valid=1 on the cycle after acceptance.
- Throughput: one result per cycle while out_ready=1 every cycle.
- Hold rule: while out_valid && !out_ready, out_idx, out_zero and out_multi are stable and no input is accepted.
- Transfer and accept in the same cycle: the new result replaces the old; out_valid stays 1.
- Transfer with no accept: out_valid drops to 0 next cycle. Output data may hold its old value.
- Encode, fixed priority (default): out_idx = lowest set bit index. For an exact one-hot input this matches the legacy 8-to-3 table (bit0→0 … bit7→7).
- Zero input: out_idx=0, out_zero=1, out_multi=0.
- Multi-hot input: out_multi=1, out_idx = the priority winner.
- err_cnt: increments by 1 on each accepted input with out_zero or out_multi set. Saturates at 2^ERR_W-1 and never wraps.
- Index arithmetic: W bits, unsigned. For N not a power of two, out_idx never exceeds N-1.
- State: no FSM beyond the output-valid flag (EMPTY / FULL). Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept+transfer or on stall.
  - FULL→EMPTY on transfer without accept.

Optional Feature:
- Macro: ONEHOT_ENC_RR_EN.
- Defined: round-robin priority.
  - Search starts at pointer p (W bits) and wraps modulo N. The winner is the first set bit at index ≥p, otherwise the lowest set bit below p.
  - On each accepted non-zero input, p ← (winner+1) mod N. Zero input leaves p unchanged.
  - p resets to 0.
- Not defined: no pointer register; fixed lowest-index priority as described above.

Test Plan:
- Reset, then 8 accepted one-hot inputs 0x01..0x80 with out_ready=1 → out_idx 0..7 on consecutive cycles, one cycle after each accept. out_zero=out_multi=0, err_cnt=0.
- in_req=0x00 accepted → out_idx=0, out_zero=1, err_cnt=1. Then in_req=0x28 → out_idx=3, out_multi=1, err_cnt=2. With RR_EN: the 0x28 case gives out_idx=3 (p=0).
- Backpressure: accept 0x04, hold out_ready=0 for 3 cycles while in_valid=1 with 0x40 → in_ready=0, out_idx stays 2. On out_ready=1: same-cycle accept, out_idx=6 next cycle.
- Saturation with ERR_W=2: 5 accepted zero vectors → err_cnt sequence 1,2,3,3,3.
- RR_EN: in_req=0xFF accepted 9 times → out_idx 0,1,…,7,0.
- Reset mid-stream: out_valid=1, assert resetn=0 for one cycle → next cycle out_valid=0, err_cnt=0, pointer=0. First post-reset 0xFF yields out_idx=0.

Source files
------------

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: N-bit request vector -> binary index, zero/multi-hot flags, saturating error count.
// Latency: result on out_valid the cycle after acceptance; one result per cycle while out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds steady. Build macro ONEHOT_ENC_RR_EN selects round-robin priority.
module onehot_encoder_pipe #(
  parameter int N     = 8,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_idx,
  output logic                  out_zero,
  output logic                  out_multi,
  output logic [ERR_W-1:0]      err_cnt
);
  // Index width is tied to N so it cannot drift out of step with the request vector.
  localparam int W = $clog2(N);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_idx_q,   out_idx_d;
  logic             out_zero_q,  out_zero_d;
  logic             out_multi_q, out_multi_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  logic             accept;
  logic [W-1:0]     enc_idx;
  logic             enc_zero;
  logic             enc_multi;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  assign enc_zero  = ~|in_req;
  assign enc_multi = |(in_req & (in_req - N'(1)));

`ifdef ONEHOT_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Round-robin winner: lowest set bit at or above the pointer, else lowest set bit below it.
  always_comb begin
    logic         hi_found;
    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = W'(i);
        end else begin
          lo_idx   = W'(i);
        end
      end
    end
    enc_idx = hi_found ? hi_idx : lo_idx;
  end

  // Pointer moves just past the winner on every accepted non-zero vector, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !enc_zero) begin
      if (int'(enc_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = enc_idx + W'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest set bit wins; all-zero encodes as index 0.
  always_comb begin
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        enc_idx = W'(i);
      end
    end
  end
`endif

  // Output slot: load on accept, empty on transfer without accept, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = enc_idx;
      out_zero_d  = enc_zero;
      out_multi_d = enc_multi;
      if ((enc_zero || enc_multi) && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and counter registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;
  assign err_cnt   = err_cnt_q;

endmodule
